// File: rtl/tx_echo_fifo.sv
// Byte FIFO plus transmit sequencer: absorbs parser bursts and feeds the UART
// one byte per tx_irq pulse, only while the UART is idle.
module tx_echo_fifo #(
    parameter int DEPTH_LOG2       = 4,
    parameter int DATA_WIDTH       = 8,
    parameter int BUSY_TIMEOUT_CLK = 7,
    parameter int TX_GAP_CLK       = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  wr_en_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  flush_i,
    output logic                  tx_irq_o,
    output logic [DATA_WIDTH-1:0] tx_data_o,
    input  logic                  tx_busy_i,
    output logic                  empty_o,
    output logic                  full_o,
    output logic [DEPTH_LOG2:0]   level_o,
    output logic [7:0]            drop_cnt_o
);
    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam int TW    = 8;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, GAP} state_t;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [DEPTH_LOG2:0]     wr_ptr, rd_ptr;
    logic [TW-1:0]           tmr;
    logic                    wr_acc, pop, gap_done;

    assign empty_o = (wr_ptr == rd_ptr);
    assign full_o  = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                     (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
    assign level_o = wr_ptr - rd_ptr;

    // A flush swallows a same-cycle write; a pop never frees room for a write while full.
    assign wr_acc   = wr_en_i && !full_o && !flush_i;
    assign pop      = (state_d == ISSUE);
    assign gap_done = (TX_GAP_CLK <= 1) || (tmr >= TW'(TX_GAP_CLK - 1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (!empty_o && !flush_i) state_d = ISSUE;
            ISSUE:     state_d = WAIT_BUSY;
            WAIT_BUSY: begin
                if (tx_busy_i)                              state_d = WAIT_DONE;
                else if (tmr == TW'(BUSY_TIMEOUT_CLK - 1))  state_d = GAP;
            end
            WAIT_DONE: if (!tx_busy_i) state_d = GAP;
            GAP:       if (gap_done) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (wr_acc) mem[wr_ptr[DEPTH_LOG2-1:0]] <= wr_data_i;
    end

    // The byte is fetched on the edge entering ISSUE so data and irq appear together.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            tmr        <= '0;
            tx_irq_o   <= 1'b0;
            tx_data_o  <= '0;
            drop_cnt_o <= '0;
        end else begin
            state_q  <= state_d;
            tx_irq_o <= pop;
            if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
            if (flush_i) begin
                rd_ptr <= wr_ptr;
            end else if (pop) begin
                rd_ptr    <= rd_ptr + 1'b1;
                tx_data_o <= mem[rd_ptr[DEPTH_LOG2-1:0]];
            end
            if (wr_en_i && full_o && !flush_i && drop_cnt_o != 8'hFF)
                drop_cnt_o <= drop_cnt_o + 8'd1;
            if (state_d != state_q)
                tmr <= '0;
            else if (state_q == WAIT_BUSY || state_q == GAP)
                tmr <= tmr + 1'b1;
        end
    end
endmodule

// File: tb/tb_tx_echo_fifo.sv
// Scoreboard bench for tx_echo_fifo with a simple UART busy model.
module tb_tx_echo_fifo;
    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       wr_en_i = 1'b0;
    logic [7:0] wr_data_i = 8'h00;
    logic       flush_i = 1'b0;
    logic       tx_irq_o;
    logic [7:0] tx_data_o;
    logic       tx_busy_i = 1'b0;
    logic       empty_o, full_o;
    logic [4:0] level_o;
    logic [7:0] drop_cnt_o;

    tx_echo_fifo dut (
        .clk_i(clk_i), .rst_i(rst_i), .wr_en_i(wr_en_i), .wr_data_i(wr_data_i),
        .flush_i(flush_i), .tx_irq_o(tx_irq_o), .tx_data_o(tx_data_o),
        .tx_busy_i(tx_busy_i), .empty_o(empty_o), .full_o(full_o),
        .level_o(level_o), .drop_cnt_o(drop_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int total = 0, bad = 0;
    int cyc = 0;
    logic [7:0] q[$];
    int exp_drop = 0;
    int irq_n = 0;
    int busy_left = 0, busy_len = 20;
    logic uart_en = 1'b1;
    int fall_cyc = 0;
    logic fall_seen = 1'b0, full_seen = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(posedge clk_i) cyc <= cyc + 1;

    // Monitor, reference model and UART model, all evaluated mid-cycle.
    always @(negedge clk_i) begin
        if (rst_i) begin
            q.delete();
            exp_drop  = 0;
            busy_left = 0;
            tx_busy_i = 1'b0;
            fall_seen = 1'b0;
        end else begin
            if (tx_irq_o === 1'b1) begin
                irq_n++;
                chk("irq_while_idle", {31'b0, tx_busy_i}, 0);
                if (fall_seen) chk("gap_after_busy", {31'b0, (cyc - fall_cyc) >= 4}, 1);
                fall_seen = 1'b0;
                chk("irq_has_expected", {31'b0, q.size() > 0}, 1);
                if (q.size() > 0) chk("tx_data", {24'b0, tx_data_o}, {24'b0, q.pop_front()});
            end
            if (flush_i) q.delete();
            else if (wr_en_i) begin
                if (q.size() >= 16) begin
                    if (exp_drop < 255) exp_drop++;
                end else q.push_back(wr_data_i);
            end
            if (full_o) full_seen = 1'b1;
            if (busy_left > 0) begin
                tx_busy_i = 1'b1;
                busy_left--;
            end else begin
                if (tx_busy_i) begin
                    fall_cyc  = cyc;
                    fall_seen = 1'b1;
                end
                tx_busy_i = 1'b0;
            end
            if (tx_irq_o === 1'b1 && uart_en) busy_left = busy_len;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic wr(input logic [7:0] b);
        wr_en_i = 1'b1;
        wr_data_i = b;
        @(posedge clk_i);
        #1;
        wr_en_i = 1'b0;
    endtask

    task automatic wait_irq(input int maxc, output int at);
        at = -1;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk_i);
            if (tx_irq_o === 1'b1) begin
                at = cyc;
                break;
            end
        end
        @(posedge clk_i);
        #1;
        if (at < 0) chk("irq_timeout", 0, 1);
    endtask

    task automatic drain(input string tag, input int maxc);
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk_i);
            if (q.size() == 0 && empty_o) break;
        end
        tick(40);
        chk({tag, "_drained"}, q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, t2, c0, n0;
        // Reset with write strobe toggling
        repeat (3) begin
            @(posedge clk_i);
            #1;
            wr_en_i = ~wr_en_i;
            wr_data_i = 8'hEE;
        end
        rst_i = 1'b0;
        wr_en_i = 1'b0;
        chk("rst_empty", {31'b0, empty_o}, 1);
        chk("rst_full", {31'b0, full_o}, 0);
        chk("rst_level", {27'b0, level_o}, 0);
        chk("rst_drop", {24'b0, drop_cnt_o}, 0);
        chk("rst_irq", {31'b0, tx_irq_o}, 0);
        chk("rst_data", {24'b0, tx_data_o}, 0);
        tick(3);
        chk("rst_no_irq", irq_n, 0);

        // Single byte, latency and post-busy gap
        busy_len = 20;
        uart_en = 1'b1;
        c0 = cyc;
        wr(8'h41);
        wait_irq(10, t);
        chk("latency", t - c0, 2);
        chk("tx_data_held", {24'b0, tx_data_o}, 32'h41);
        wr(8'h42);
        wait_irq(60, t2);
        chk("second_after_busy", {31'b0, t2 > t + 20}, 1);
        drain("single", 200);
        chk("single_level", {27'b0, level_o}, 0);
        chk("single_empty", {31'b0, empty_o}, 1);

        // Burst into full FIFO while the UART is still busy
        wr(8'hAA);
        wait_irq(10, t);
        for (int i = 0; i < 18; i++) wr(8'(i));
        chk("burst_full", {31'b0, full_o}, 1);
        chk("burst_level", {27'b0, level_o}, 16);
        chk("burst_drop", {24'b0, drop_cnt_o}, 2);
        chk("burst_drop_model", {24'b0, drop_cnt_o}, exp_drop);
        drain("burst", 1000);
        chk("burst_empty", {31'b0, empty_o}, 1);

        // Busy never rises: timeout path
        uart_en = 1'b0;
        n0 = irq_n;
        wr(8'h55);
        wait_irq(10, t);
        tick(30);
        chk("timeout_once", irq_n - n0, 1);
        wr(8'h57);
        wr(8'h58);
        wait_irq(10, t);
        wait_irq(30, t2);
        chk("timeout_period", t2 - t, 11);
        drain("timeout", 100);

        // Flush during the first transfer, with a write in the flush cycle
        uart_en = 1'b1;
        busy_len = 20;
        n0 = irq_n;
        for (int i = 0; i < 5; i++) wr(8'h10 + 8'(i));
        tick(3);
        flush_i = 1'b1;
        wr_en_i = 1'b1;
        wr_data_i = 8'hF0;
        tick(1);
        flush_i = 1'b0;
        wr_en_i = 1'b0;
        tick(60);
        chk("flush_one_irq", irq_n - n0, 1);
        chk("flush_empty", {31'b0, empty_o}, 1);
        chk("flush_level", {27'b0, level_o}, 0);
        chk("flush_drop", {24'b0, drop_cnt_o}, exp_drop);

        // Sustained stream wrapping the pointers
        busy_len = 3;
        full_seen = 1'b0;
        n0 = irq_n;
        for (int i = 0; i < 40; i++) begin
            wr(8'h80 + 8'(i));
            tick(9);
        end
        drain("wrap", 300);
        chk("wrap_never_full", {31'b0, full_seen}, 0);
        chk("wrap_count", irq_n - n0, 40);
        chk("final_drop", {24'b0, drop_cnt_o}, exp_drop);
        chk("final_level", {27'b0, level_o}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
